mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/arb_starve_ctr.sv | 54 +++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_t : which requester owns the transaction in flight
//   STARVE_LIMIT_DEF : default number of consecutive data grants allowed
//                      while a fetch is waiting
//   CNT_W   : width of the starvation counter (limit must fit in it)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int STARVE_LIMIT_DEF = 3;
    localparam int CNT_W            = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, the data port and the unified memory port of the
// arbiter.
//   Fetch : if_req, if_addr -> if_rdata, if_ack
//   Data  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ack
//   Memory: mem_req, mem_we, mem_addr, mem_wdata -> mem_gnt, mem_rvalid,
//           mem_rdata
// Handshakes: a requester raises *_req with stable payload and holds it until
// the one-cycle *_ack pulse. On the memory side mem_req is held with stable
// payload until mem_gnt; the response arrives as a one-cycle mem_rvalid no
// earlier than the cycle after mem_gnt.
// Modports:
//   master : the arbiter (drives acks, read data and the memory request)
//   slave  : the environment (requesters and the memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic [XLEN-1:0] if_rdata;
    logic            if_ack;

    logic            d_req;
    logic [3:0]      d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_rdata;
    logic            d_ack;

    logic            mem_req;
    logic [3:0]      mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
// Grant decision between fetch and data requests plus the starvation
// counter that lets a waiting fetch in after STARVE_LIMIT data grants.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   if_req      : fetch request pending
//   d_req       : data request pending
//   idle        : arbiter is in IDLE; decisions and counter updates only here
//   grant       : a request is granted this cycle
//   owner       : winner of the arbitration (valid with grant)
//   starve_cnt  : consecutive data grants taken while a fetch waited
// ---------------------------------------------------------------------------
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic             d_req,
    input  logic             idle,
    output logic             grant,
    output owner_t           owner,
    output logic [CNT_W-1:0] starve_cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Data has priority; a fetch wins when it is alone or has been passed
    // over LIMIT times in a row.
    always_comb begin
        grant = idle && (if_req || d_req);
        owner = OWN_D;
        if (if_req && (!d_req || starve_cnt == LIMIT)) begin
            owner = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (idle) begin
            if (!if_req || owner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                // Here if_req=1 and data won, so a fetch was passed over.
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the instruction fetch port and the data
// (MEM stage) port. At most one transaction is in flight:
//   IDLE  -> arbitrate, latch owner and request payload
//   ISSUE -> present mem_req until mem_gnt
//   WAIT  -> wait for mem_rvalid, capture read data for the owner
//   RESP  -> one-cycle ack to the owner, back to IDLE
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : mem_arbiter_if master modport (fetch, data, memory sides)
//   busy        : high whenever the FSM is not in IDLE
//   state       : current FSM state (observation)
//   starve_cnt  : starvation counter (observation)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.master    bus,
    output logic             busy,
    output state_t           state,
    output logic [CNT_W-1:0] starve_cnt
);

    logic            grant;
    owner_t          grant_owner;
    owner_t          owner;

    logic            req_q;
    logic [3:0]      we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            if_ack_q;
    logic            d_ack_q;
    logic [XLEN-1:0] if_rdata_q;
    logic [XLEN-1:0] d_rdata_q;

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .if_req     (bus.if_req),
        .d_req      (bus.d_req),
        .idle       (state == IDLE),
        .grant      (grant),
        .owner      (grant_owner),
        .starve_cnt (starve_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            req_q      <= 1'b0;
            we_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner <= grant_owner;
                        req_q <= 1'b1;
                        if (grant_owner == OWN_IF) begin
                            // Fetches never write, regardless of d_we.
                            addr_q  <= bus.if_addr;
                            we_q    <= '0;
                            wdata_q <= '0;
                        end else begin
                            addr_q  <= bus.d_addr;
                            we_q    <= bus.d_we;
                            wdata_q <= bus.d_wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt) begin
                        req_q   <= 1'b0;
                        we_q    <= '0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // mem_rvalid is only meaningful here; elsewhere it is ignored.
                    if (bus.mem_rvalid) begin
                        if (owner == OWN_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ack_q   <= 1'b1;
                        end else begin
                            d_rdata_q <= bus.mem_rdata;
                            d_ack_q   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule
